// File: rtl/phys_free_list.sv
// Physical-register free list: circular FIFO of free indices with an
// in-list bitmap; grants up to two registers and reclaims up to two per cycle.
module phys_free_list #(
  parameter int NUM_PREG = 64,
  parameter int PREG_W   = 6,
  parameter int NUM_ARCH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc_req_1,
  input  logic              alloc_req_2,
  output logic              alloc_grant,
  output logic [PREG_W-1:0] alloc_preg_1,
  output logic [PREG_W-1:0] alloc_preg_2,
  input  logic              rt_flag_1,
  input  logic [PREG_W-1:0] fp_i_1,
  input  logic              rt_flag_2,
  input  logic [PREG_W-1:0] fp_i_2,
  output logic [PREG_W:0]   free_count,
  output logic              empty,
  output logic              err_double_free
);

  localparam int NFREE0 = NUM_PREG - NUM_ARCH;
  localparam logic [PREG_W+1:0] CAP = (PREG_W+2)'(NUM_PREG);
  localparam logic [NUM_PREG-1:0] INL0 =
    {{NFREE0{1'b1}}, {NUM_ARCH{1'b0}}};

  logic [PREG_W-1:0]   fifo_q [NUM_PREG];
  logic [PREG_W-1:0]   head_q, head_d;
  logic [PREG_W-1:0]   tail_q, tail_d;
  logic [PREG_W-1:0]   wr2_idx;
  logic [PREG_W:0]     cnt_q, cnt_d;
  logic [NUM_PREG-1:0] inl_q, inl_d;
  logic                err_q, err_d;
  logic [1:0]          need, take, nfree;
  logic                hit1, hit2, leg1, leg2;
  logic [PREG_W+1:0]   room1, room2;

  always_comb begin
    need = {1'b0, alloc_req_1} + {1'b0, alloc_req_2};
    alloc_grant = {{(PREG_W-1){1'b0}}, need} <= cnt_q;
    take = alloc_grant ? need : 2'd0;
    alloc_preg_1 = fifo_q[head_q];
    alloc_preg_2 = alloc_req_1 ? fifo_q[head_q + PREG_W'(1)]
                               : fifo_q[head_q];
  end

  // Release legality: p0 is silently ignored; a set bitmap bit, a slot-2
  // duplicate of slot 1, or a count overflow is dropped and flagged.
  always_comb begin
    hit1  = rt_flag_1 && (fp_i_1 != '0);
    hit2  = rt_flag_2 && (fp_i_2 != '0);
    room1 = {1'b0, cnt_q} + (PREG_W+2)'(1);
    leg1  = hit1 && !inl_q[fp_i_1] && (room1 <= CAP);
    room2 = room1 + {{PREG_W{1'b0}}, 1'b0, leg1};
    leg2  = hit2 && !inl_q[fp_i_2] &&
            !(hit1 && (fp_i_1 == fp_i_2)) && (room2 <= CAP);
    nfree = {1'b0, leg1} + {1'b0, leg2};
  end

  always_comb begin
    wr2_idx = tail_q + {{(PREG_W-1){1'b0}}, leg1};
    head_d  = head_q + {{(PREG_W-2){1'b0}}, take};
    tail_d  = tail_q + {{(PREG_W-2){1'b0}}, nfree};
    cnt_d   = cnt_q - {{(PREG_W-1){1'b0}}, take}
                    + {{(PREG_W-1){1'b0}}, nfree};
    err_d   = err_q | (hit1 & ~leg1) | (hit2 & ~leg2);
    inl_d   = inl_q;
    if (alloc_grant && alloc_req_1) inl_d[alloc_preg_1] = 1'b0;
    if (alloc_grant && alloc_req_2) inl_d[alloc_preg_2] = 1'b0;
    if (leg1) inl_d[fp_i_1] = 1'b1;
    if (leg2) inl_d[fp_i_2] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_PREG; k++)
        fifo_q[k] <= (k < NFREE0) ? PREG_W'(NUM_ARCH + k) : '0;
    end else begin
      if (leg1) fifo_q[tail_q]  <= fp_i_1;
      if (leg2) fifo_q[wr2_idx] <= fp_i_2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= PREG_W'(NFREE0);
      cnt_q  <= (PREG_W+1)'(NFREE0);
      inl_q  <= INL0;
      err_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      inl_q  <= inl_d;
      err_q  <= err_d;
    end
  end

  assign free_count      = cnt_q;
  assign empty           = (cnt_q == '0);
  assign err_double_free = err_q;

endmodule
